// File: rtl/biriq_br_pkg.sv
// Shared types and constants for the IXU branch-resolve stage.
package biriq_br_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGEU = 3'd5,
    BR_JAL  = 3'd6,
    BR_JALR = 3'd7
  } br_type_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  localparam logic [31:0] C_LINK_OFFSET = 32'd4;

endpackage

// File: rtl/biriq_br_cond.sv
// Branch condition evaluation from the compare-unit flags.
module biriq_br_cond
  import biriq_br_pkg::*;
(
  input  br_type_e br_type,
  input  logic     mts,
  input  logic     mtu,
  input  logic     eq,
  output logic     taken
);

  // Map branch type and compare flags to the resolved direction
  always_comb begin
    taken = 1'b0;
    unique case (br_type)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = !eq;
      BR_BLT:  taken = !(mts || eq);
      BR_BGE:  taken = mts || eq;
      BR_BLTU: taken = !(mtu || eq);
      BR_BGEU: taken = mtu || eq;
      BR_JAL:  taken = 1'b1;
      BR_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/biriq_branch_resolve.sv
// Branch resolve stage: direction/target resolution, mispredict redirect,
// registered writeback and predictor update, wrong-path squash.
module biriq_branch_resolve
  import biriq_br_pkg::*;
#(
  parameter int C_ROB_ID_W        = 6,
  parameter bit C_HAS_C_EXTENSION = 1'b0
) (
  input  logic                  cpu_clock_i,
  input  logic                  cpu_rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            br_type_i,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           imm_i,
  input  logic [31:0]           rs1_i,
  input  logic                  mts_i,
  input  logic                  mtu_i,
  input  logic                  eq_i,
  input  logic                  pred_taken_i,
  input  logic [31:0]           pred_target_i,
  input  logic [C_ROB_ID_W-1:0] rob_id_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [C_ROB_ID_W-1:0] res_rob_id_o,
  output logic [31:0]           res_link_o,
  output logic                  res_exc_o,
  output logic                  redirect_o,
  output logic [31:0]           redirect_pc_o,
  output logic                  bu_valid_o,
  output logic [31:0]           bu_pc_o,
  output logic [31:0]           bu_target_o,
  output logic                  bu_taken_o
);

  state_e      state_q;
  // Set while the held result is the branch that opened the current squash window
  logic        res_mispred_q;

  br_type_e    br_type_p0;
  logic        taken_p0;
  logic [31:0] target_p0;
  logic [31:0] link_p0;
  logic [31:0] next_pc_p0;
  logic        exc_p0;
  logic        mispred_p0;
  logic        bu_en_p0;
  logic        accept_p0;
  logic        load_p0;
  logic        keep_on_flush;

  function automatic logic misaligned(input logic taken, input logic [31:0] tgt);
    return taken && tgt[1] && !C_HAS_C_EXTENSION;
  endfunction

  assign br_type_p0 = br_type_e'(br_type_i);

  biriq_br_cond u_cond (
    .br_type (br_type_p0),
    .mts     (mts_i),
    .mtu     (mtu_i),
    .eq      (eq_i),
    .taken   (taken_p0)
  );

  // Stage p0: resolve target, exception and mispredict for the incoming uop
  always_comb begin
    target_p0  = (br_type_p0 == BR_JALR) ? ((rs1_i + imm_i) & ~32'd1) : (pc_i + imm_i);
    link_p0    = pc_i + C_LINK_OFFSET;
    exc_p0     = misaligned(taken_p0, target_p0);
    // A not-taken prediction that matches carries no meaningful target
    mispred_p0 = !exc_p0 && ((taken_p0 != pred_taken_i) ||
                             (taken_p0 && (target_p0 != pred_target_i)));
    next_pc_p0 = taken_p0 ? target_p0 : link_p0;
    // jal targets are static; only conditional branches and jalr train the predictor
    bu_en_p0   = !exc_p0 && (br_type_p0 != BR_JAL);
  end

  // Handshake: wrong-path uops are always swallowed while squashing
  always_comb begin
    ready_o       = (state_q == ST_SQUASH) || !res_valid_o || res_ready_i;
    accept_p0     = valid_i && ready_o && !flush_i;
    load_p0       = accept_p0 && (state_q == ST_RUN);
    keep_on_flush = (state_q == ST_SQUASH) && res_mispred_q;
  end

  // Stage p1: output register, single-cycle pulses and squash FSM
  always_ff @(posedge cpu_clock_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      state_q       <= ST_RUN;
      res_mispred_q <= 1'b0;
      res_valid_o   <= 1'b0;
      res_rob_id_o  <= '0;
      res_link_o    <= '0;
      res_exc_o     <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      bu_valid_o    <= 1'b0;
      bu_pc_o       <= '0;
      bu_target_o   <= '0;
      bu_taken_o    <= 1'b0;
    end else begin
      redirect_o <= 1'b0;
      bu_valid_o <= 1'b0;
      if (load_p0) begin
        res_valid_o   <= 1'b1;
        res_rob_id_o  <= rob_id_i;
        res_link_o    <= link_p0;
        res_exc_o     <= exc_p0;
        res_mispred_q <= mispred_p0;
        redirect_o    <= mispred_p0;
        redirect_pc_o <= next_pc_p0;
        bu_valid_o    <= bu_en_p0;
        bu_pc_o       <= pc_i;
        bu_target_o   <= target_p0;
        bu_taken_o    <= taken_p0;
        state_q       <= mispred_p0 ? ST_SQUASH : ST_RUN;
      end else begin
        if (res_ready_i || (flush_i && !keep_on_flush)) begin
          res_valid_o   <= 1'b0;
          res_mispred_q <= 1'b0;
        end
        if (flush_i) begin
          state_q <= ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_biriq_branch_resolve.sv
// Directed, table-driven bench for biriq_branch_resolve.
module tb_biriq_branch_resolve;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        valid;
  logic        ready;
  logic [2:0]  br_type;
  logic [31:0] pc, imm, rs1;
  logic        mts, mtu, eq;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [5:0]  rob_id;
  logic        res_valid;
  logic        res_ready;
  logic [5:0]  res_rob_id;
  logic [31:0] res_link;
  logic        res_exc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        bu_valid;
  logic [31:0] bu_pc, bu_target;
  logic        bu_taken;

  int checks   = 0;
  int failures = 0;

  biriq_branch_resolve #(.C_ROB_ID_W(6), .C_HAS_C_EXTENSION(1'b0)) dut (
    .cpu_clock_i   (clk),
    .cpu_rst_ni    (rst_n),
    .flush_i       (flush),
    .valid_i       (valid),
    .ready_o       (ready),
    .br_type_i     (br_type),
    .pc_i          (pc),
    .imm_i         (imm),
    .rs1_i         (rs1),
    .mts_i         (mts),
    .mtu_i         (mtu),
    .eq_i          (eq),
    .pred_taken_i  (pred_taken),
    .pred_target_i (pred_target),
    .rob_id_i      (rob_id),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_rob_id_o  (res_rob_id),
    .res_link_o    (res_link),
    .res_exc_o     (res_exc),
    .redirect_o    (redirect),
    .redirect_pc_o (redirect_pc),
    .bu_valid_o    (bu_valid),
    .bu_pc_o       (bu_pc),
    .bu_target_o   (bu_target),
    .bu_taken_o    (bu_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  t;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        mts;
    logic        mtu;
    logic        eq;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_exc;
    logic        e_bu;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_uop(input logic [2:0] t, input logic [31:0] p, input logic [31:0] im,
                         input logic [31:0] r1, input logic s, input logic u, input logic e,
                         input logic pt, input logic [31:0] ptg, input logic [5:0] id);
    br_type = t; pc = p; imm = im; rs1 = r1; mts = s; mtu = u; eq = e;
    pred_taken = pt; pred_target = ptg; rob_id = id;
  endtask

  // Correctly predicted not-taken beq
  task automatic set_good(input logic [5:0] id);
    set_uop(3'd0, 32'h0000_8000, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, id);
  endtask

  // Taken beq predicted not-taken
  task automatic set_bad(input logic [5:0] id);
    set_uop(3'd0, 32'h0000_9000, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, id);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
    check({tag, "_bu_valid"}, {31'd0, bu_valid}, 32'd0);
    check({tag, "_res_link"}, res_link, 32'd0);
    check({tag, "_res_rob"}, {26'd0, res_rob_id}, 32'd0);
    check({tag, "_rpc"}, redirect_pc, 32'd0);
    check({tag, "_bu_target"}, bu_target, 32'd0);
    check({tag, "_bu_pc"}, bu_pc, 32'd0);
    check({tag, "_res_exc"}, {31'd0, res_exc}, 32'd0);
    check({tag, "_bu_taken"}, {31'd0, bu_taken}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; res_ready = 1'b1;
    set_good(6'd0);

    //          type   pc            imm           rs1          mts mtu eq pt ptgt          taken tgt          redir rpc           exc bu
    vecs[0]  = '{3'd0, 32'h00001000, 32'h00000040, 32'h0,       1'b0,1'b0,1'b1,1'b0,32'h0,        1'b1,32'h00001040,1'b1,32'h00001040,1'b0,1'b1};
    vecs[1]  = '{3'd2, 32'h00002000, 32'h00000100, 32'h0,       1'b0,1'b0,1'b0,1'b1,32'h00002100, 1'b1,32'h00002100,1'b0,32'h0,       1'b0,1'b1};
    vecs[2]  = '{3'd2, 32'h00002000, 32'h00000100, 32'h0,       1'b1,1'b0,1'b0,1'b1,32'h00002100, 1'b0,32'h00002100,1'b1,32'h00002004,1'b0,1'b1};
    vecs[3]  = '{3'd7, 32'h00000500, 32'h00000010, 32'h00002001,1'b0,1'b0,1'b0,1'b1,32'h00002010, 1'b1,32'h00002010,1'b0,32'h0,       1'b0,1'b1};
    vecs[4]  = '{3'd7, 32'h00003000, 32'h00000010, 32'h00002003,1'b0,1'b0,1'b0,1'b1,32'h00002012, 1'b1,32'h00002012,1'b0,32'h0,       1'b1,1'b0};
    vecs[5]  = '{3'd6, 32'h00004000, 32'h00000800, 32'h0,       1'b0,1'b0,1'b0,1'b1,32'h00004800, 1'b1,32'h00004800,1'b0,32'h0,       1'b0,1'b0};
    vecs[6]  = '{3'd1, 32'h00005000, 32'hFFFFFFF0, 32'h0,       1'b0,1'b0,1'b1,1'b0,32'h0000DEAD, 1'b0,32'h00004FF0,1'b0,32'h0,       1'b0,1'b1};
    vecs[7]  = '{3'd5, 32'hFFFFFFF0, 32'h00000020, 32'h0,       1'b0,1'b1,1'b0,1'b1,32'h00000010, 1'b1,32'h00000010,1'b0,32'h0,       1'b0,1'b1};
    vecs[8]  = '{3'd4, 32'h00006000, 32'h00000008, 32'h0,       1'b0,1'b0,1'b0,1'b1,32'h0000600C, 1'b1,32'h00006008,1'b1,32'h00006008,1'b0,1'b1};
    vecs[9]  = '{3'd3, 32'h00006100, 32'h00000020, 32'h0,       1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h00006120,1'b0,32'h0,       1'b0,1'b1};
    vecs[10] = '{3'd1, 32'h00007000, 32'h00000006, 32'h0,       1'b0,1'b0,1'b0,1'b1,32'h00007006, 1'b1,32'h00007006,1'b0,32'h0,       1'b1,1'b0};
    vecs[11] = '{3'd6, 32'h00000100, 32'h00000020, 32'h0,       1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h00000120,1'b1,32'h00000120,1'b0,1'b0};

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table-driven single uops; each followed by a flush cycle to leave SQUASH
    for (int i = 0; i < 12; i++) begin
      set_uop(vecs[i].t, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].mts, vecs[i].mtu,
              vecs[i].eq, vecs[i].pt, vecs[i].ptgt, 6'(i + 1));
      valid = 1'b1;
      step();
      valid = 1'b0;
      check($sformatf("v%0d_res_valid", i), {31'd0, res_valid}, 32'd1);
      check($sformatf("v%0d_rob", i), {26'd0, res_rob_id}, i + 1);
      check($sformatf("v%0d_link", i), res_link, vecs[i].pc + 32'd4);
      check($sformatf("v%0d_exc", i), {31'd0, res_exc}, {31'd0, vecs[i].e_exc});
      check($sformatf("v%0d_redirect", i), {31'd0, redirect}, {31'd0, vecs[i].e_redir});
      if (vecs[i].e_redir)
        check($sformatf("v%0d_rpc", i), redirect_pc, vecs[i].e_rpc);
      check($sformatf("v%0d_bu_valid", i), {31'd0, bu_valid}, {31'd0, vecs[i].e_bu});
      if (vecs[i].e_bu) begin
        check($sformatf("v%0d_bu_taken", i), {31'd0, bu_taken}, {31'd0, vecs[i].e_taken});
        check($sformatf("v%0d_bu_target", i), bu_target, vecs[i].e_tgt);
        check($sformatf("v%0d_bu_pc", i), bu_pc, vecs[i].pc);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      check($sformatf("v%0d_redirect_pulse", i), {31'd0, redirect}, 32'd0);
      check($sformatf("v%0d_bu_pulse", i), {31'd0, bu_valid}, 32'd0);
      check($sformatf("v%0d_consumed", i), {31'd0, res_valid}, 32'd0);
    end

    // Backpressure: result held for 3 cycles, second uop stalled then accepted
    res_ready = 1'b0;
    set_good(6'd21);
    valid = 1'b1;
    step();
    set_uop(3'd1, 32'h0000_A000, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 6'd22);
    for (int c = 0; c < 3; c++) begin
      check("bp_ready_low", {31'd0, ready}, 32'd0);
      check("bp_hold_valid", {31'd0, res_valid}, 32'd1);
      check("bp_hold_rob", {26'd0, res_rob_id}, 32'd21);
      check("bp_hold_link", res_link, 32'h0000_8004);
      step();
    end
    res_ready = 1'b1;
    #1;
    check("bp_ready_high", {31'd0, ready}, 32'd1);
    step();
    valid = 1'b0;
    check("bp_second_valid", {31'd0, res_valid}, 32'd1);
    check("bp_second_rob", {26'd0, res_rob_id}, 32'd22);
    check("bp_second_link", res_link, 32'h0000_A004);
    step();
    check("bp_drained", {31'd0, res_valid}, 32'd0);

    // Squash window: wrong-path uops dropped, mispredicting entry survives flush
    res_ready = 1'b0;
    set_bad(6'd30);
    valid = 1'b1;
    step();
    check("sq_redirect", {31'd0, redirect}, 32'd1);
    check("sq_rpc", redirect_pc, 32'h0000_9040);
    for (int k = 0; k < 2; k++) begin
      set_good(6'(31 + k));
      #1;
      check("sq_ready", {31'd0, ready}, 32'd1);
      step();
      check("sq_drop_redirect", {31'd0, redirect}, 32'd0);
      check("sq_drop_bu", {31'd0, bu_valid}, 32'd0);
      check("sq_drop_rob", {26'd0, res_rob_id}, 32'd30);
    end
    valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sq_kept_valid", {31'd0, res_valid}, 32'd1);
    check("sq_kept_rob", {26'd0, res_rob_id}, 32'd30);
    check("sq_run_ready", {31'd0, ready}, 32'd0);
    res_ready = 1'b1;
    step();
    check("sq_consumed", {31'd0, res_valid}, 32'd0);

    // Flush in RUN clears a held non-mispredicting result
    res_ready = 1'b0;
    set_good(6'd40);
    valid = 1'b1;
    step();
    valid = 1'b0;
    check("run_held", {31'd0, res_valid}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("run_flush_clear", {31'd0, res_valid}, 32'd0);
    res_ready = 1'b1;

    // Mispredict together with flush: killed, no redirect, stays RUN
    set_bad(6'd41);
    valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("mf_redirect", {31'd0, redirect}, 32'd0);
    check("mf_res_valid", {31'd0, res_valid}, 32'd0);
    set_good(6'd42);
    step();
    valid = 1'b0;
    check("mf_run_accept", {31'd0, res_valid}, 32'd1);
    check("mf_run_rob", {26'd0, res_rob_id}, 32'd42);
    step();

    // Asynchronous reset while squashing with a pending redirect
    res_ready = 1'b0;
    set_bad(6'd50);
    valid = 1'b1;
    step();
    valid = 1'b0;
    check("rst_pre_redirect", {31'd0, redirect}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    set_good(6'd51);
    valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("rst_flush_drop", {31'd0, res_valid}, 32'd0);
    set_good(6'd52);
    step();
    valid = 1'b0;
    check("rst_run_accept", {31'd0, res_valid}, 32'd1);
    check("rst_run_rob", {26'd0, res_rob_id}, 32'd52);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/biriq_branch_resolve.md
Name: biriq_branch_resolve

Overview:
- Stage directly downstream of the integer compare unit (biriq_branch) in the IXU branch pipe.
- Consumes the compare flags mts/mtu/eq with the branch µop context and resolves the actual direction and target.
- Checks the outcome against the frontend prediction, raises a one-cycle redirect on mispredict, and emits a registered writeback (link value) and a predictor update.
- Drops wrong-path branches until the core flush arrives.

Parameters:
C_ROB_ID_W, 6, width of ROB tag
C_HAS_C_EXTENSION, 0, 1: 2-byte aligned targets legal; 0: target[1]=1 on a taken branch raises misaligned exception

Ports:
cpu_clock_i  in  1  core clock
cpu_rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  core pipeline flush
valid_i  in  1  branch µop valid
ready_o  out  1  stage can accept µop
br_type_i  in  3  0 beq, 1 bne, 2 blt, 3 bge, 4 bltu, 5 bgeu, 6 jal, 7 jalr
pc_i  in  32  µop PC
imm_i  in  32  sign-extended offset
rs1_i  in  32  rs1 (jalr base)
mts_i / mtu_i / eq_i  in  1 each  compare flags: rs1>rs2 signed, rs1>rs2 unsigned, rs1==rs2
pred_taken_i  in  1  predicted direction
pred_target_i  in  32  predicted target
rob_id_i  in  C_ROB_ID_W  ROB tag
res_valid_o  out  1  writeback valid
res_ready_i  in  1  writeback accepted
res_rob_id_o  out  C_ROB_ID_W  tag
res_link_o  out  32  pc+4
res_exc_o  out  1  misaligned-target exception
redirect_o  out  1  one-cycle mispredict pulse
redirect_pc_o  out  32  correct next PC
bu_valid_o  out  1  predictor update pulse
bu_pc_o / bu_target_o  out  32  update PC / resolved target
bu_taken_o  out  1  resolved direction

Behaviour:
- Reset (cpu_rst_ni=0, asynchronous): all outputs 0; state RUN.
- Handshake: accept when valid_i & ready_o. ready_o = !res_valid_o | res_ready_i (in SQUASH: 1).
- Output register holds all res_* fields stable until res_ready_i.
- Latency: accept at edge N; res_*, redirect_o and bu_* are visible after edge N.
- redirect_o and bu_valid_o are single-cycle pulses independent of res_ready_i.
- Direction:
  - beq: eq; bne: !eq
  - blt: !(mts|eq); bge: mts|eq
  - bltu: !(mtu|eq); bgeu: mtu|eq
  - jal and jalr: always taken
- Target:
  - jalr: (rs1_i+imm_i) & ~1
  - all others: pc_i+imm_i
  - All adds are 32-bit wrap-around; overflow is ignored.
- Exception: taken, target[1]=1 and C_HAS_C_EXTENSION=0 -> res_exc_o=1, no redirect, bu_valid_o=0.
- Mispredict: taken != pred_taken_i, or taken & target != pred_target_i.
  - redirect_pc_o = taken ? target : pc_i+4
  - If pred_taken_i=0 and the branch is not taken, pred_target_i is ignored.
- bu_valid_o pulses for every accepted, non-exception conditional branch, and for jalr.
- FSM:
  - RUN: mispredict accepted -> SQUASH.
  - SQUASH: valid_i µops are accepted and dropped (no res, redirect or bu); flush_i -> RUN.
- flush_i:
  - Kills an incoming µop in the same cycle; flush wins over valid_i.
  - Clears res_valid_o, except when the held entry is the mispredicting branch that caused SQUASH; that entry is older than the flush and is retained.
  - In RUN, also clears any held result.
- Mispredict + flush_i in the same cycle: the µop is killed, no redirect, state stays RUN.
- Reset mid-operation: everything is discarded immediately, including a pending redirect pulse.

Decomposition:
- Shared package biriq_br_pkg:
  - br_type_e enum (8 codes)
  - state enum {RUN, SQUASH}
  - constant C_LINK_OFFSET=4
- One natural sub-module: biriq_br_cond, combinational (br_type, mts, mtu, eq) -> taken.
- Target/compare logic and the register/FSM stay in the top.

Test Plan:
- beq, eq_i=1, pc=0x1000, imm=0x40, pred_taken=0 -> next cycle redirect_o=1, redirect_pc=0x1040, bu_taken=1, res_link=0x1004, state SQUASH.
- blt, mts=0 eq=0, pred_taken=1, pred_target=pc+imm -> taken, no redirect, bu_valid=1; repeat with mts=1 -> not taken, redirect_pc=pc+4.
- jalr, rs1=0x2003, imm=0x10, pred_target=0x2012 -> target 0x2012, no redirect; with C_HAS_C_EXTENSION=0 and target 0x2016 -> res_exc_o=1, redirect_o=0.
- Hold res_ready_i=0 for 3 cycles after accept -> res fields stable, ready_o=0, a second µop is stalled; res_ready_i=1 -> the second µop is accepted the same cycle.
- After a mispredict, drive 2 more valid µops -> both accepted, none produce res/redirect/bu; assert flush_i -> state RUN and the mispredicting entry is still presented until consumed.
- Deassert cpu_rst_ni while res_valid_o=1 and in SQUASH -> all outputs 0 asynchronously, state RUN; valid_i together with flush_i -> dropped.
